// File: rtl/fp_dot_sequencer.sv
// Streaming dot-product sequencer around a combinational FP MAC: accumulates
// a*b pairs in arrival order. Optional sticky exception flag: FP_DOT_EXC_STICKY_EN.
module fp_dot_sequencer #(
  parameter int BIT_WIDTH  = 16,
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 7,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] vec_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_a,
  input  logic [BIT_WIDTH-1:0] in_b,
  output logic [BIT_WIDTH-1:0] mac_a,
  output logic [BIT_WIDTH-1:0] mac_b,
  output logic [BIT_WIDTH-1:0] mac_c,
  input  logic [BIT_WIDTH-1:0] mac_res,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_data,
`ifdef FP_DOT_EXC_STICKY_EN
  output logic                 busy,
  output logic                 exc_flag
`else
  output logic                 busy
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_r;
  logic [BIT_WIDTH-1:0] acc_r;
  logic [LEN_WIDTH-1:0] cnt_r;
  logic [LEN_WIDTH-1:0] len_q_r;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic                 busy_r;
  logic                 hs_s;
  logic                 last_s;

  assign hs_s   = in_valid & in_ready_r;
  assign last_s = (cnt_r == (len_q_r - LEN_WIDTH'(1)));

  // The MAC sees the live operands and the registered accumulator; data bits pass untouched.
  assign mac_a     = in_a;
  assign mac_b     = in_b;
  assign mac_c     = acc_r;
  assign out_data  = acc_r;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;

  // Control FSM with handshake flags registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      acc_r       <= {BIT_WIDTH{1'b0}};
      cnt_r       <= {LEN_WIDTH{1'b0}};
      len_q_r     <= {LEN_WIDTH{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            acc_r   <= {BIT_WIDTH{1'b0}};
            cnt_r   <= {LEN_WIDTH{1'b0}};
            len_q_r <= vec_len;
            busy_r  <= 1'b1;
            if (vec_len == {LEN_WIDTH{1'b0}}) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
            end else begin
              state_r    <= ACCUM;
              in_ready_r <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (hs_s) begin
            acc_r <= mac_res;
            cnt_r <= cnt_r + LEN_WIDTH'(1);
            if (last_s) begin
              state_r     <= DONE;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

`ifdef FP_DOT_EXC_STICKY_EN
  function automatic logic exp_all_ones(input logic [BIT_WIDTH-1:0] x);
    return &x[MANT_WIDTH +: EXP_WIDTH];
  endfunction

  logic exc_r;
  assign exc_flag = exc_r;

  // Sticky Inf/NaN observation over a run, cleared only by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_r <= 1'b0;
    end else if ((state_r == IDLE) && start) begin
      exc_r <= 1'b0;
    end else if ((state_r == ACCUM) && hs_s &&
                 (exp_all_ones(in_a) || exp_all_ones(in_b) || exp_all_ones(mac_res))) begin
      exc_r <= 1'b1;
    end else begin
      exc_r <= exc_r;
    end
  end
`endif

endmodule

// File: tb/tb_fp_dot_sequencer.sv
// Directed bench for fp_dot_sequencer with a behavioural bfloat16 MAC attached.
module tb_fp_dot_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  vec_len = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = 16'h0000;
  logic [15:0] in_b = 16'h0000;
  logic [15:0] mac_a, mac_b, mac_c, mac_res;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        busy;
`ifdef FP_DOT_EXC_STICKY_EN
  logic        exc_flag;
`endif

  int n_chk = 0;
  int n_fail = 0;

  fp_dot_sequencer #(.BIT_WIDTH(16), .EXP_WIDTH(8), .MANT_WIDTH(7), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_res(mac_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef FP_DOT_EXC_STICKY_EN
    .busy(busy), .exc_flag(exc_flag)
`else
    .busy(busy)
`endif
  );

  always #5 clk = ~clk;

  function automatic real bf_to_real(input logic [15:0] x);
    real r;
    if (x[14:7] == 8'd0) return 0.0;
    r = (1.0 + real'(x[6:0]) / 128.0) * (2.0 ** (real'(int'(x[14:7])) - 127.0));
    if (x[15]) r = -r;
    return r;
  endfunction

  function automatic logic [15:0] real_to_bf(input real r);
    real  a;
    int   e;
    int   m;
    logic s;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = $rtoi((a - 1.0) * 128.0);
    return {s, e[7:0], m[6:0]};
  endfunction

  function automatic logic [15:0] mac_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c);
    if ((&a[14:7]) || (&b[14:7]) || (&c[14:7])) return 16'h7F80;
    return real_to_bf(bf_to_real(a) * bf_to_real(b) + bf_to_real(c));
  endfunction

  always_comb mac_res = mac_fn(mac_a, mac_b, mac_c);

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [7:0]        len;
    logic [3:0][15:0]  a;
    logic [3:0][15:0]  b;
    logic [15:0]       exp;
  } vec_t;

  vec_t vecs[6];

  task automatic set_vec(input int idx, input logic [7:0] len,
                         input logic [15:0] a0, input logic [15:0] b0,
                         input logic [15:0] a1, input logic [15:0] b1,
                         input logic [15:0] a2, input logic [15:0] b2,
                         input logic [15:0] a3, input logic [15:0] b3,
                         input logic [15:0] exp);
    vecs[idx].len = len;
    vecs[idx].a   = {a3, a2, a1, a0};
    vecs[idx].b   = {b3, b2, b1, b0};
    vecs[idx].exp = exp;
  endtask

  // Full run with in_valid held high and out_ready asserted as soon as the result appears.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    start = 1'b1; vec_len = v.len;
    @(negedge clk);
    start = 1'b0;
    chk1("busy_after_start", busy, 1'b1);
    for (int k = 0; k < int'(v.len); k++) begin
      in_valid = 1'b1; in_a = v.a[k]; in_b = v.b[k];
      chk1("in_ready_accum", in_ready, 1'b1);
      chk1("out_valid_early", out_valid, 1'b0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk1("in_ready_done", in_ready, 1'b0);
    chk1("out_valid_done", out_valid, 1'b1);
    chk16("out_data", out_data, v.exp);
    chk16("mac_c_acc", mac_c, v.exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk1("out_valid_idle", out_valid, 1'b0);
    chk1("busy_idle", busy, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_in_ready"}, in_ready, 1'b0);
    chk1({tag, "_out_valid"}, out_valid, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk16({tag, "_out_data"}, out_data, 16'h0000);
    chk16({tag, "_mac_c"}, mac_c, 16'h0000);
  endtask

  logic [5:0] stall_pat;

  initial begin
    set_vec(0, 8'd2, 16'h3F80, 16'h4000, 16'h4000, 16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h40C0);
    set_vec(1, 8'd0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000);
    set_vec(2, 8'd1, 16'h4040, 16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h40C0);
    set_vec(3, 8'd3, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h0, 16'h0, 16'h4040);
    set_vec(4, 8'd2, 16'h4000, 16'h4000, 16'hBF80, 16'h3F80, 16'h0, 16'h0, 16'h0, 16'h0, 16'h4040);
    set_vec(5, 8'd4, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h4080);

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Stalled input, start pulses ignored in ACCUM and DONE, then output backpressure.
    stall_pat = 6'b101001;
    @(negedge clk);
    start = 1'b1; vec_len = 8'd3;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      start = (i == 1);
      vec_len = (i == 1) ? 8'd0 : 8'd3;
      in_valid = stall_pat[i]; in_a = 16'h3F80; in_b = 16'h3F80;
      chk1("stall_in_ready", in_ready, 1'b1);
      chk1("stall_out_valid", out_valid, 1'b0);
      @(negedge clk);
    end
    in_valid = 1'b0; start = 1'b0;
    for (int j = 0; j < 5; j++) begin
      start = (j == 2);
      chk1("bp_out_valid", out_valid, 1'b1);
      chk16("bp_out_data", out_data, 16'h4040);
      chk1("bp_in_ready", in_ready, 1'b0);
      chk1("bp_busy", busy, 1'b1);
      @(negedge clk);
    end
    start = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk1("b2b_idle_valid", out_valid, 1'b0);
    // Back-to-back: start in the very first IDLE cycle.
    start = 1'b1; vec_len = 8'd1;
    @(negedge clk);
    start = 1'b0;
    chk1("b2b_busy", busy, 1'b1);
    in_valid = 1'b1; in_a = 16'h3F80; in_b = 16'h4000;
    chk1("b2b_in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk1("b2b_out_valid", out_valid, 1'b1);
    chk16("b2b_out_data", out_data, 16'h4000);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset mid-run after two handshakes, then a clean follow-up run.
    start = 1'b1; vec_len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_a = 16'h3F80; in_b = 16'h4000;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk16("pre_reset_acc", mac_c, 16'h4080);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[2]);

    // Maximum length: only the final pair contributes, and completion must not come early.
    @(negedge clk);
    start = 1'b1; vec_len = 8'd255;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 255; k++) begin
      in_valid = 1'b1;
      in_a = (k == 254) ? 16'h3F80 : 16'h0000;
      in_b = (k == 254) ? 16'h3F80 : 16'h0000;
      if (out_valid !== 1'b0) chk1("maxlen_early_valid", out_valid, 1'b0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk1("maxlen_out_valid", out_valid, 1'b1);
    chk16("maxlen_out_data", out_data, 16'h3F80);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

`ifdef FP_DOT_EXC_STICKY_EN
    start = 1'b1; vec_len = 8'd2;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_a = 16'h7F80; in_b = 16'h3F80;
    chk1("exc_before", exc_flag, 1'b0);
    @(negedge clk);
    chk1("exc_set", exc_flag, 1'b1);
    in_a = 16'h3F80; in_b = 16'h3F80;
    @(negedge clk);
    in_valid = 1'b0;
    chk1("exc_done_valid", out_valid, 1'b1);
    chk1("exc_done", exc_flag, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk1("exc_idle", exc_flag, 1'b1);
    start = 1'b1; vec_len = 8'd0;
    @(negedge clk);
    start = 1'b0;
    chk1("exc_cleared", exc_flag, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
